// File: rtl/req_arbiter_4.sv
// req_arbiter_4: four-requester arbiter for one shared resource.
// Fixed (3 > 2 > 1 > 0) or round-robin priority is chosen at each idle
// arbitration. The owner keeps the grant until it drops its request or
// until it has held the grant for MAX_HOLD cycles. A preempted owner is
// masked for the following arbitration unless it is the only requester.
module req_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       mode,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_t     state_q;
    logic [3:0] gnt_q;
    logic [1:0] gnt_id_q;
    logic       timeout_q;
    logic [1:0] last_q;
    logic [3:0] mask_q;
    logic [7:0] hold_q;

    logic [3:0] eff_req_d;
    logic [1:0] base_d;
    logic [1:0] win_d;
    logic       win_found_d;
    logic [1:0] idx_d;

    // Winner selection: apply the penalty mask unless the masked requester
    // is alone, then scan downward cyclically from the start index. Fixed
    // priority is the round-robin scan with a start index of 3.
    always_comb begin
        eff_req_d   = req;
        win_d       = 2'd0;
        win_found_d = 1'b0;
        idx_d       = 2'd0;
        if ((req & ~mask_q) != 4'b0000) begin
            eff_req_d = req & ~mask_q;
        end
        base_d = mode ? (last_q - 2'd1) : 2'd3;
        for (int unsigned k = 0; k < 4; k++) begin
            idx_d = base_d - k[1:0];
            if (!win_found_d && eff_req_d[idx_d]) begin
                win_d       = idx_d;
                win_found_d = 1'b1;
            end
        end
    end

    // Grant state machine with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            timeout_q <= 1'b0;
            last_q    <= '0;
            mask_q    <= '0;
            hold_q    <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The mask only ever covers one arbitration, granted or not.
                    mask_q <= '0;
                    if (req != 4'b0000) begin
                        gnt_q    <= 4'b0001 << win_d;
                        gnt_id_q <= win_d;
                        last_q   <= win_d;
                        hold_q   <= 8'd1;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (!req[gnt_id_q]) begin
                        gnt_q    <= '0;
                        gnt_id_q <= '0;
                        state_q  <= IDLE;
                    end else if (hold_q == MAX_HOLD_C) begin
                        gnt_q     <= '0;
                        gnt_id_q  <= '0;
                        timeout_q <= 1'b1;
                        mask_q    <= gnt_q;
                        state_q   <= IDLE;
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_req_arbiter_4.sv
// Directed bench for req_arbiter_4 built with MAX_HOLD = 4.
module tb_req_arbiter_4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       mode;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int unsigned tests;
    int unsigned failed;

    req_arbiter_4 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mode      (mode),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare {gnt, gnt_id, gnt_valid, timeout} against expectations.
    task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                       input logic eto);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {gnt, gnt_id, gnt_valid, timeout};
        exp = {eg, eid, |eg, eto};
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed gnt/id/valid/timeout=%b required %b", tag, obs, exp);
        end
    endtask

    initial begin
        int unsigned rr_seq [5];
        logic [1:0]  w;

        tests  = 0;
        failed = 0;
        rr_seq = '{3, 2, 1, 0, 3};

        // Reset held for two cycles with no requests.
        rst  = 1'b1;
        req  = 4'b0000;
        mode = 1'b0;
        tick();
        tick();
        chk("reset", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        tick();
        chk("idle_no_req", 4'b0000, 2'd0, 1'b0);

        // Fixed priority: 2 beats 1, one idle cycle, then 1.
        req = 4'b0110;
        tick();
        chk("fixed_grant2", 4'b0100, 2'd2, 1'b0);
        req = 4'b0010;
        tick();
        chk("fixed_release2", 4'b0000, 2'd0, 1'b0);
        tick();
        chk("fixed_grant1", 4'b0010, 2'd1, 1'b0);
        req = 4'b0000;
        tick();
        chk("fixed_release1", 4'b0000, 2'd0, 1'b0);

        // Asynchronous reset during a grant to requester 1.
        req = 4'b0010;
        tick();
        chk("pre_rst_grant1", 4'b0010, 2'd1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_grant", 4'b0000, 2'd0, 1'b0);
        req = 4'b0000;
        tick();
        rst = 1'b0;

        // Round-robin rotation starting from last = 0.
        mode = 1'b1;
        req  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            w = 2'(rr_seq[i]);
            for (int c = 0; c < 3; c++) begin
                tick();
                chk($sformatf("rr_grant_%0d_c%0d", i, c), 4'b0001 << w, w, 1'b0);
            end
            req = 4'b1111 & ~(4'b0001 << w);
            tick();
            chk($sformatf("rr_idle_%0d", i), 4'b0000, 2'd0, 1'b0);
            req = (i == 4) ? 4'b0000 : 4'b1111;
        end
        tick();
        chk("rr_quiet", 4'b0000, 2'd0, 1'b0);

        // Timeout with penalty mask: 3 preempted, 0 next, then 3 again.
        mode = 1'b0;
        req  = 4'b1001;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("to_hold3_c%0d", c), 4'b1000, 2'd3, 1'b0);
        end
        tick();
        chk("to_pulse", 4'b0000, 2'd0, 1'b1);
        tick();
        chk("to_masked_grant0", 4'b0001, 2'd0, 1'b0);
        req = 4'b1000;
        tick();
        chk("to_release0", 4'b0000, 2'd0, 1'b0);
        tick();
        chk("to_regrant3", 4'b1000, 2'd3, 1'b0);
        req = 4'b0000;
        tick();
        chk("to_quiet", 4'b0000, 2'd0, 1'b0);

        // Sole requester keeps winning through repeated timeouts.
        req = 4'b0100;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                chk($sformatf("sole_r%0d_c%0d", r, c), 4'b0100, 2'd2, 1'b0);
            end
            tick();
            chk($sformatf("sole_to_r%0d", r), 4'b0000, 2'd0, 1'b1);
        end
        req = 4'b0000;
        tick();
        chk("sole_quiet", 4'b0000, 2'd0, 1'b0);

        // Release coinciding with the hold limit: no timeout, no mask.
        req = 4'b1001;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("lim_hold3_c%0d", c), 4'b1000, 2'd3, 1'b0);
        end
        req = 4'b0001;
        tick();
        chk("lim_release", 4'b0000, 2'd0, 1'b0);
        req = 4'b1001;
        tick();
        chk("lim_no_mask", 4'b1000, 2'd3, 1'b0);
        req = 4'b0000;
        tick();
        chk("lim_quiet", 4'b0000, 2'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
